// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, mispredict redirect/flush with fetch squash,
// dmem wait freezes, saturating perf counters and a sticky memory-timeout flag.
module hazard_ctrl #(
   parameter int unsigned FLUSH_HOLD  = 1,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [4:0]       i_ID_rs1_addr,
   input  logic [4:0]       i_ID_rs2_addr,
   input  logic             i_ID_rs1_used,
   input  logic             i_ID_rs2_used,
   input  logic [4:0]       i_EX_rd_addr,
   input  logic             i_EX_mem_rd,
   input  logic             i_EX_mispred,
   input  logic             i_MEM_req,
   input  logic             i_MEM_ready,
   output logic             o_pc_stall,
   output logic             o_IF_ID_stall,
   output logic             o_ID_EX_stall,
   output logic             o_EX_MEM_stall,
   output logic             o_IF_ID_flush,
   output logic             o_ID_EX_flush,
   output logic             o_redirect,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_redirects
);

   localparam int unsigned HoldW = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;
   localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [HoldW-1:0] HoldInit = HoldW'(FLUSH_HOLD);
   localparam logic [WaitW-1:0] WaitMax  = WaitW'(TIMEOUT_CYC);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StRun, StRedirect, StMemWait} state_e;

   state_e             r_state;
   state_e             w_state_nxt;
   state_e             w_eff_state;
   logic [HoldW-1:0]   r_hold;
   logic [HoldW-1:0]   w_hold_nxt;
   logic [WaitW-1:0]   r_wait;
   logic               r_timeout;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic [CNT_W-1:0]   r_redir_cnt;
   logic               w_mem_wait;
   logic               w_rs1_hit;
   logic               w_rs2_hit;
   logic               w_load_use;

   always_comb begin
      w_mem_wait = i_MEM_req & ~i_MEM_ready;
      w_rs1_hit  = i_ID_rs1_used & (i_ID_rs1_addr == i_EX_rd_addr);
      w_rs2_hit  = i_ID_rs2_used & (i_ID_rs2_addr == i_EX_rd_addr);
      w_load_use = i_EX_mem_rd & (i_EX_rd_addr != 5'd0) & (w_rs1_hit | w_rs2_hit);
   end

   // Leaving MEM_WAIT resolves to REDIRECT/RUN within the same cycle.
   always_comb begin
      if (r_state == StMemWait) begin
         w_eff_state = (r_hold != '0) ? StRedirect : StRun;
      end else begin
         w_eff_state = r_state;
      end
   end

   always_comb begin
      o_pc_stall     = 1'b0;
      o_IF_ID_stall  = 1'b0;
      o_ID_EX_stall  = 1'b0;
      o_EX_MEM_stall = 1'b0;
      o_IF_ID_flush  = 1'b0;
      o_ID_EX_flush  = 1'b0;
      o_redirect     = 1'b0;
      w_state_nxt    = StRun;
      w_hold_nxt     = r_hold;
      if (w_mem_wait) begin
         o_pc_stall     = 1'b1;
         o_IF_ID_stall  = 1'b1;
         o_ID_EX_stall  = 1'b1;
         o_EX_MEM_stall = 1'b1;
         w_state_nxt    = StMemWait;
      end else if (i_EX_mispred) begin
         o_redirect    = 1'b1;
         o_IF_ID_flush = 1'b1;
         o_ID_EX_flush = 1'b1;
         w_hold_nxt    = HoldInit;
         w_state_nxt   = (FLUSH_HOLD > 0) ? StRedirect : StRun;
      end else if ((w_eff_state == StRedirect) && (r_hold != '0)) begin
         o_IF_ID_flush = 1'b1;
         w_hold_nxt    = r_hold - HoldW'(1);
         w_state_nxt   = (r_hold == HoldW'(1)) ? StRun : StRedirect;
      end else if ((w_eff_state == StRun) && w_load_use) begin
         o_pc_stall    = 1'b1;
         o_IF_ID_stall = 1'b1;
         o_ID_EX_flush = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StRun;
         r_hold      <= '0;
         r_wait      <= '0;
         r_timeout   <= 1'b0;
         r_stall_cnt <= '0;
         r_redir_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         if (w_mem_wait) begin
            if (r_wait != WaitMax) begin
               r_wait <= r_wait + WaitW'(1);
            end
            if (r_wait == WaitLast) begin
               r_timeout <= 1'b1;
            end
         end else begin
            r_wait <= '0;
         end
         if (o_pc_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (o_redirect && !(&r_redir_cnt)) begin
            r_redir_cnt <= r_redir_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      o_mem_timeout  = r_timeout;
      o_stall_cycles = r_stall_cnt;
      o_redirects    = r_redir_cnt;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core with 2-bit branch prediction. It generates every stall and flush for the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. Sources are load-use hazards, EX-stage mispredict redirects (with a configurable post-redirect fetch squash) and data-memory wait handshakes. It also keeps saturating performance counters and a sticky memory-timeout flag.

## Interface
- FLUSH_HOLD, 1: extra cycles IF/ID stays flushed after a redirect, covering synchronous imem latency; 0 = no hold.
- TIMEOUT_CYC, 256: consecutive memory-wait cycles that set o_mem_timeout; ≥1.
- CNT_W, 32: width of the performance counters.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ID_rs1_addr, i_ID_rs2_addr  in  5  source registers of the instruction in ID.
- i_ID_rs1_used, i_ID_rs2_used  in  1  source register actually read.
- i_EX_rd_addr  in  5  destination register of the instruction in EX.
- i_EX_mem_rd  in  1  instruction in EX is a load.
- i_EX_mispred  in  1  branch/jump in EX resolved mispredicted.
- i_MEM_req  in  1  MEM stage has an active dmem access.
- i_MEM_ready  in  1  dmem completes the access this cycle.
- o_pc_stall, o_IF_ID_stall, o_ID_EX_stall, o_EX_MEM_stall  out  1  hold the register.
- o_IF_ID_flush, o_ID_EX_flush  out  1  load a bubble (all-zero) next edge.
- o_redirect  out  1  PC mux selects the EX-computed target.
- o_mem_timeout  out  1  sticky timeout flag.
- o_stall_cycles  out  CNT_W  cycles with o_pc_stall=1, saturating.
- o_redirects  out  CNT_W  redirects taken, saturating.

## Operation
- FSM states: RUN, REDIRECT, MEM_WAIT. Reset state is RUN.
- Control outputs are Mealy (combinational from state and inputs). Counters, hold counter, wait counter and timeout flag are registered.
- mem_wait = i_MEM_req & ~i_MEM_ready.
- load_use = i_EX_mem_rd & (i_EX_rd_addr≠0) & ((i_ID_rs1_used & rs1==rd) | (i_ID_rs2_used & rs2==rd)).
- Priority, evaluated every cycle in any state:
  1. mem_wait: all four stalls=1, all flushes=0, o_redirect=0. Go to or stay in MEM_WAIT. Hold counter frozen; EX is frozen, so a pending mispredict is still present afterwards.
  2. i_EX_mispred: o_redirect=1, o_IF_ID_flush=1, o_ID_EX_flush=1, stalls=0. Load the hold counter with FLUSH_HOLD. Go to REDIRECT if FLUSH_HOLD>0, else RUN. Overrides load_use, since the ID instruction is wrong-path.
  3. REDIRECT with hold counter >0: o_IF_ID_flush=1, everything else 0, load_use ignored. Decrement the counter; return to RUN when it reaches 0.
  4. load_use in RUN: o_pc_stall=1, o_IF_ID_stall=1, o_ID_EX_flush=1. Exactly one bubble.
  5. Otherwise all outputs 0.
- Leaving MEM_WAIT (mem_wait falls): go to REDIRECT if the hold counter is >0, else RUN. Priorities then apply in that same cycle.
- A flush is never asserted together with the stall of the same register. IF/ID ignores flush while stalled, so this invariant is mandatory.
- Wait counter:
  - Counts consecutive mem_wait cycles; clears when mem_wait=0.
  - o_mem_timeout sets on the edge where the counter reaches TIMEOUT_CYC.
  - It is cleared only by reset.
- Counters saturate at 2^CNT_W−1 and never wrap.
  - o_stall_cycles increments on each edge where o_pc_stall=1.
  - o_redirects increments on each edge where o_redirect=1.

## Timing
- Reset (async assert, sync-safe release):
  - All outputs 0 and state=RUN.
  - Hold, wait and perf counters 0.
  - o_mem_timeout 0.
- Control latency is 0 cycles: outputs respond in the same cycle as their inputs. Counters and flags update at the next edge.
- Load-use costs 1 cycle: the ID instruction re-presents the next cycle with EX holding a bubble.
- Mispredict costs 2+FLUSH_HOLD fetch slots.
- A mem_wait of N cycles costs N full-pipeline stall cycles and adds N to o_stall_cycles.
- Reset mid-REDIRECT or mid-MEM_WAIT returns immediately to RUN with counters cleared.

## Test plan
- Load-use: EX lw rd=5, ID add rs1=5 used → one cycle with pc/IF_ID stall=1 and ID_EX_flush=1; o_stall_cycles=1. Repeat with rd=0 → no stall.
- Mispredict, FLUSH_HOLD=1: i_EX_mispred for 1 cycle → cycle 0: redirect=1 with IF_ID and ID_EX flush; cycle 1: IF_ID_flush only; cycle 2: all 0; o_redirects=1.
- Mispredict together with load_use in the same cycle → redirect and flushes only, no stall.
- Mem wait: i_MEM_req=1, i_MEM_ready=0 for 3 cycles, then ready=1 → three cycles with all stalls=1, o_stall_cycles=3, then all 0.
- Mem wait during REDIRECT (hold=1) → freeze with flush=0 and hold counter kept; after ready, one IF_ID_flush cycle.
- TIMEOUT_CYC=4: 4 wait cycles → o_mem_timeout=1 and stays 1 after ready. CNT_W=2 with 5 stall cycles → o_stall_cycles=3. Reset → all outputs 0.
